// File: rtl/micro_sequencer.sv
// ============================================================================
// micro_sequencer : microprogram counter / next-address logic for the MM core
// Optional macro: USEQ_ILLEGAL_TRAP_EN (illegal dispatch halts instead of skip)
// Revision: 1.0
// ============================================================================
`default_nettype none

module micro_sequencer #(
  parameter int          UADDR_W     = 7,
  parameter int          UCODE_DEPTH = 75,
  parameter logic [7:0]  END_OPCODE  = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  input  logic [7:0]         opcode,
  input  logic               z_flag,
  input  logic               cores_done,
  input  logic               bt,
  input  logic [1:0]         condition,
  input  logic [UADDR_W-1:0] jump_addr,
  output logic [15:0]        upc,
  output logic               ops_en,
  output logic               running,
  output logic               halted,
  output logic               illegal,
  output logic [15:0]        instr_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [UADDR_W-1:0] c_LAST_ADDR = UADDR_W'(UCODE_DEPTH - 1);
  localparam logic [UADDR_W-1:0] c_ONE       = UADDR_W'(1);

  state_t             state_q, state_d;
  logic [UADDR_W-1:0] upc_q, upc_d;
  logic               illegal_q, illegal_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [UADDR_W-1:0] w_upc_inc;
  logic               w_legal_op;

  assign w_upc_inc  = (upc_q == c_LAST_ADDR) ? '0 : upc_q + c_ONE;
  assign w_legal_op = 32'(opcode) < UCODE_DEPTH;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      upc_q     <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      upc_q     <= upc_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    upc_d     = upc_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_RUN: begin
        if (!stall) begin
          if (bt) begin
            // Dispatch outranks any branch condition in the same word
            if (opcode == END_OPCODE) begin
              state_d = S_HALT;
              upc_d   = '0;
            end else if (w_legal_op) begin
              upc_d = UADDR_W'(opcode);
              if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            end else begin
              illegal_d = 1'b1;
              upc_d     = '0;
`ifdef USEQ_ILLEGAL_TRAP_EN
              state_d   = S_HALT;
`else
              state_d   = S_RUN;
`endif
            end
          end else begin
            case (condition)
              2'b00:   upc_d = jump_addr;
              2'b01:   upc_d = z_flag      ? jump_addr : w_upc_inc;
              2'b10:   upc_d = !z_flag     ? jump_addr : w_upc_inc;
              default: upc_d = !cores_done ? jump_addr : w_upc_inc;
            endcase
          end
        end
      end
      default: begin
        upc_d = '0;
        if (start) begin
          state_d   = S_RUN;
          illegal_d = 1'b0;
          cnt_d     = 16'd0;
        end
      end
    endcase
  end

  assign upc         = 16'(upc_q);
  assign running     = (state_q == S_RUN);
  assign halted      = (state_q == S_HALT);
  assign ops_en      = running && !stall;
  assign illegal     = illegal_q;
  assign instr_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_micro_sequencer.sv
// ============================================================================
// tb_micro_sequencer : vector-table + scoreboard bench for micro_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_micro_sequencer;

`ifdef USEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        rst, start, stall, bt, z, cd;
    logic [1:0]  cond;
    logic [6:0]  ja;
    logic [7:0]  op;
    logic [15:0] e_upc;
    logic        e_ops, e_run, e_halt, e_ill;
    logic [15:0] e_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, stall, z_flag, cores_done, bt;
  logic [7:0]  opcode;
  logic [1:0]  condition;
  logic [6:0]  jump_addr;
  logic [15:0] upc, instr_count;
  logic        ops_en, running, halted, illegal;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  micro_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .opcode(opcode),
    .z_flag(z_flag), .cores_done(cores_done), .bt(bt), .condition(condition),
    .jump_addr(jump_addr), .upc(upc), .ops_en(ops_en), .running(running),
    .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic s, input logic st,
                              input logic b, input logic [1:0] c, input int j,
                              input int o, input logic zz, input logic d,
                              input int eu, input logic eo, input logic er,
                              input logic eh, input logic ei, input int ec);
    vec_t v;
    v.rst = r; v.start = s; v.stall = st; v.bt = b; v.cond = c;
    v.ja = 7'(j); v.op = 8'(o); v.z = zz; v.cd = d;
    v.e_upc = 16'(eu); v.e_ops = eo; v.e_run = er; v.e_halt = eh;
    v.e_ill = ei; v.e_cnt = 16'(ec);
    return v;
  endfunction

  task automatic cmp(input string name, input int step, input logic [15:0] act,
                     input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL step %0d %s: got %0d expected %0d", step, name, act, req);
    end
  endtask

  task automatic apply(input vec_t v, input int step);
    vec_t e;
    rst = v.rst; start = v.start; stall = v.stall; bt = v.bt;
    condition = v.cond; jump_addr = v.ja; opcode = v.op;
    z_flag = v.z; cores_done = v.cd;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    cmp("upc", step, upc, e.e_upc);
    cmp("ops_en", step, 16'(ops_en), 16'(e.e_ops));
    cmp("running", step, 16'(running), 16'(e.e_run));
    cmp("halted", step, 16'(halted), 16'(e.e_halt));
    cmp("illegal", step, 16'(illegal), 16'(e.e_ill));
    cmp("instr_count", step, instr_count, e.e_cnt);
  endtask

  initial begin
    //               rst st stl bt cond ja  op  z cd | upc ops run hlt ill cnt
    tbl.push_back(mk(1, 0, 0, 0, 2'd0, 0,  0,  0, 0,  0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2'd0, 9,  0,  0, 0,  0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'd0, 9,  0,  0, 0,  0,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2'd1, 5,  0,  0, 0,  1,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2'd2, 9,  0,  1, 0,  2,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2'd3, 50, 11, 0, 0,  11, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'd0, 66, 0,  0, 0,  66, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'd1, 69, 0,  1, 0,  69, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'd0, 66, 0,  0, 0,  66, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'd1, 69, 0,  0, 0,  67, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'd0, 74, 0,  0, 0,  74, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'd1, 9,  0,  0, 0,  0,  1, 1, 0, 0, 1));
    // stalled dispatch for three cycles, then it completes once
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 1, 1, 2'd0, 0, 20, 0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 2'd0, 0,  20, 0, 0,  20, 1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 2'd0, 40, 0,  0, 0,  40, 1, 1, 0, 0, 2));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0, 0, 2'd3, 40, 0, 0, 0, 40, 1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 2'd3, 40, 0,  0, 1,  41, 1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 2'd0, 3,  0,  0, 0,  3,  1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 1, 2'd0, 0,  255, 0, 0, 0,  0, 0, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 2'd0, 9,  0,  0, 0,  0,  0, 0, 1, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 2'd0, 9,  0,  0, 0,  0,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2'd0, 0,  100, 0, 0, 0, !TRAP, !TRAP, TRAP, 1, 0));
    if (TRAP)
      tbl.push_back(mk(0, 0, 0, 1, 2'd0, 0, 74, 0, 0, 0, 0, 0, 1, 1, 0));
    else
      tbl.push_back(mk(0, 0, 0, 1, 2'd0, 0, 74, 0, 0, 74, 1, 1, 0, 1, 1));
    tbl.push_back(mk(1, 1, 1, 1, 2'd0, 9,  11, 0, 0,  0,  0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Hand-written run: restart, then a burst of random legal dispatches
    begin
      vec_t v;
      int op;
      v = mk(0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      apply(v, 100);
      for (int k = 1; k <= 12; k++) begin
        op = int'($urandom_range(0, 74));
        v = mk(0, 0, 0, 1, 2'd0, 0, op, 0, 0, op, 1, 1, 0, 0, k);
        apply(v, 100 + k);
      end
      // illegal just above the last legal address
      v = mk(0, 0, 0, 1, 2'd0, 0, 75, 0, 0, 0, !TRAP, !TRAP, TRAP, 1, 12);
      apply(v, 200);
      v = mk(1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(v, 201);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
